// File: rtl/signed_sequential_divider_restoring.sv
// Signed restoring radix-2 divider. It takes a 2*width-bit dividend and a width-bit divisor,
// retires one quotient bit per cycle, and has fixed latency with valid/ready handshakes.
module signed_sequential_divider_restoring #(
    parameter int width = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*width-1:0]   dividend,
    input  logic [width-1:0]     divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*width-1:0]   quotient,
    output logic [width-1:0]     remainder,
    output logic                 div_by_zero
);
    localparam int W2 = 2 * width;
    localparam int CW = $clog2(W2);
    localparam logic [CW-1:0] LAST = CW'(W2 - 1);

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [W2-1:0]    dvd_mag;
    logic [W2-1:0]    q_mag;
    logic [width:0]   dvs_mag;
    logic [width:0]   partial;
    logic [width-1:0] dvd_low;
    logic             dvd_neg, dvs_neg, dvs_zero, overflow;
    logic [CW-1:0]    count;
    logic             out_valid_q;

    logic [W2:0]      dvd_ext, dvd_abs;
    logic [width:0]   dvs_ext, dvs_abs;
    logic [width+1:0] shifted, trial;
    logic [W2-1:0]    q_fix;
    logic [width-1:0] r_fix;

    // Magnitudes are taken one bit wider so that the most negative operand survives negation.
    always_comb begin
        dvd_ext = {dividend[W2-1], dividend};
        dvs_ext = {divisor[width-1], divisor};
        dvd_abs = dividend[W2-1] ? -dvd_ext : dvd_ext;
        dvs_abs = divisor[width-1] ? -dvs_ext : dvs_ext;
        shifted = {partial, dvd_mag[W2-1]};
        trial   = shifted - {1'b0, dvs_mag};
        q_fix   = (dvd_neg ^ dvs_neg) ? -q_mag : q_mag;
        r_fix   = dvd_neg ? -partial[width-1:0] : partial[width-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: assign a default first so that every path through the case drives state_nxt
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)               state_nxt = DIV;
            DIV:  if (count == LAST)          state_nxt = FIX;
            FIX:                              state_nxt = DONE;
            DONE: if (out_valid_q && out_ready) state_nxt = IDLE;
            default:                          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = out_valid_q;
    end

    // NOTE: registered state uses non-blocking assignments, so every branch sees the
    // values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_mag     <= '0;
            q_mag       <= '0;
            dvs_mag     <= '0;
            partial     <= '0;
            dvd_low     <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dvs_zero    <= 1'b0;
            overflow    <= 1'b0;
            count       <= '0;
            out_valid_q <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    dvd_mag  <= dvd_abs[W2-1:0];
                    dvs_mag  <= dvs_abs;
                    dvd_low  <= dividend[width-1:0];
                    dvd_neg  <= dividend[W2-1];
                    dvs_neg  <= divisor[width-1];
                    dvs_zero <= (divisor == '0);
                    overflow <= (dividend == {1'b1, {(W2-1){1'b0}}}) && (divisor == '1);
                    partial  <= '0;
                    q_mag    <= '0;
                    count    <= '0;
                end
                DIV: begin
                    // A clear sign bit on the trial difference means the divisor fits, so keep the trial.
                    if (!trial[width+1]) partial <= trial[width:0];
                    else                 partial <= shifted[width:0];
                    q_mag   <= {q_mag[W2-2:0], ~trial[width+1]};
                    dvd_mag <= {dvd_mag[W2-2:0], 1'b0};
                    count   <= count + 1'b1;
                end
                FIX: begin
                    if (dvs_zero) begin
                        quotient    <= '1;
                        remainder   <= dvd_low;
                        div_by_zero <= 1'b1;
                    end else if (overflow) begin
                        quotient    <= {1'b1, {(W2-1){1'b0}}};
                        remainder   <= '0;
                        div_by_zero <= 1'b0;
                    end else begin
                        quotient    <= q_fix;
                        remainder   <= r_fix;
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (!out_valid_q)   out_valid_q <= 1'b1;
                    else if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_signed_sequential_divider_restoring.sv
// Self-checking bench for signed_sequential_divider_restoring. It drives directed and random
// division vectors and compares the outputs against an arithmetic reference model.
module tb_signed_sequential_divider_restoring;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [17:0] dividend = '0;
    logic [8:0]  divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [17:0] quotient;
    logic [8:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [17:0] exp_q;
    logic [8:0]  exp_r;
    logic        exp_z;

    always #5 clk = ~clk;

    signed_sequential_divider_restoring #(.width(9)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: language division truncates toward zero and % follows the dividend sign.
    function automatic logic [27:0] model(input logic [17:0] a, input logic [8:0] b);
        longint la, lb, lq, lr;
        logic [17:0] q;
        logic [8:0]  r;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (lb == 0) return {18'h3FFFF, a[8:0], 1'b1};
        if (la == -131072 && lb == -1) return {a, 9'd0, 1'b0};
        lq = la / lb;
        lr = la % lb;
        q = lq[17:0];
        r = lr[8:0];
        return {q, r, 1'b0};
    endfunction

    // Whenever a result is presented, it must match the model and input must be blocked.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("quotient", 64'(quotient), 64'(exp_q));
            check("remainder", 64'(remainder), 64'(exp_r));
            check("div_by_zero", 64'(div_by_zero), 64'(exp_z));
            check("in_ready_while_valid", 64'(in_ready), 64'd0);
        end
    end

    task automatic run_op(input logic [17:0] a, input logic [8:0] b, input int hold,
                          input bit use_lit, input logic [17:0] lq, input logic [8:0] lr,
                          input logic lz);
        int lat;
        if (use_lit) check("model_pin", 64'(model(a, b)), 64'({lq, lr, lz}));
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            check("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        {exp_q, exp_r, exp_z} = model(a, b);
        #1;
        in_valid = 1'b0;
        dividend = 18'($urandom);
        divisor  = 9'($urandom);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        check("latency", 64'(lat), 64'd20);
        if (!out_valid) return;
        if (use_lit) begin
            check("lit_quotient", 64'(quotient), 64'(lq));
            check("lit_remainder", 64'(remainder), 64'(lr));
            check("lit_div_by_zero", 64'(div_by_zero), 64'(lz));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            // Present a new operation while the result is held; it must not be taken.
            in_valid = 1'b1;
            dividend = 18'd5;
            divisor  = 9'd1;
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("valid_drops", 64'(out_valid), 64'd0);
        check("ready_after_handshake", 64'(in_ready), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_quotient", 64'(quotient), 64'd0);
        check("rst_remainder", 64'(remainder), 64'd0);
        check("rst_div_by_zero", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(18'd100, 9'd7, 0, 1, 18'd14, 9'd2, 1'b0);
        run_op(18'(-100), 9'd7, 0, 1, 18'(-14), 9'(-2), 1'b0);
        run_op(18'd100, 9'(-7), 0, 1, 18'(-14), 9'd2, 1'b0);
        run_op(18'(-100), 9'(-7), 0, 1, 18'd14, 9'(-2), 1'b0);
        run_op(18'(-72), 9'd9, 0, 1, 18'(-8), 9'd0, 1'b0);
        run_op(18'(-65280), 9'(-256), 0, 1, 18'd255, 9'd0, 1'b0);
        run_op(18'd1234, 9'd0, 0, 1, 18'h3FFFF, 9'h0D2, 1'b1);
        run_op(18'h20000, 9'h1FF, 0, 1, 18'h20000, 9'd0, 1'b0);
        run_op(18'd0, 9'd5, 0, 1, 18'd0, 9'd0, 1'b0);
        run_op(18'd1000, 9'(-13), 5, 1, 18'(-76), 9'd12, 1'b0);

        // Abort an operation mid-division with an asynchronous reset.
        in_valid = 1'b1;
        dividend = 18'd100;
        divisor  = 9'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_quotient", 64'(quotient), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(18'd17, 9'd5, 0, 1, 18'd3, 9'd2, 1'b0);

        for (int i = 0; i < 500; i++)
            run_op(18'($urandom), 9'($urandom), 0, 0, 18'd0, 9'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
